// File: rtl/spi_master_tx_pkg.sv
// Shared definitions for the SPI mode-0 master transmitter: limits, byte width,
// FSM state type and a constant helper used to size the timing counter.
package spi_master_tx_pkg;

    localparam int SPI_MIN_HALF_DIV = 3;
    localparam int SPI_MIN_CS_SETUP = 2;
    localparam int SPI_MIN_CS_HOLD  = 2;
    localparam int SPI_MIN_CS_GAP   = 3;
    localparam int SPI_BYTE_W       = 8;
    localparam int SPI_BIT_CNT_W    = $clog2(SPI_BYTE_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } spi_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Byte shifter for the SPI transmitter: parallel load, MSB-first shift-out,
// registered MOSI, bit counter and end-of-byte flag.
module spi_tx_shifter
    import spi_master_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [SPI_BYTE_W-1:0] data,
    input  logic                  shift,
    output logic                  mosi,
    output logic                  last_bit,
    output logic                  empty
);

    logic [SPI_BYTE_W-1:0]    shreg;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt;

    // Load a new byte or advance one bit on each SCLK fall; MOSI follows the next MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            mosi    <= 1'b0;
            empty   <= 1'b0;
        end else if (load) begin
            shreg   <= data;
            bit_cnt <= '0;
            mosi    <= data[SPI_BYTE_W-1];
            empty   <= 1'b0;
        end else if (shift) begin
            shreg   <= {shreg[SPI_BYTE_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + SPI_BIT_CNT_W'(1);
            mosi    <= shreg[SPI_BYTE_W-2];
            empty   <= (bit_cnt == '1);
        end
    end

    // High while the final bit of the byte is on MOSI.
    assign last_bit = (bit_cnt == '1);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 MSB-first master transmitter. Bytes arrive over valid/ready and are
// grouped into one CS-low frame until a byte tagged last. All outputs registered;
// a single down-counter times every state.
module spi_master_tx
    import spi_master_tx_pkg::*;
#(
    parameter int HALF_DIV = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [SPI_BYTE_W-1:0] data_in,
    input  logic                  last_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic                  busy_out,
    output logic                  byte_done_out,
    output logic                  spi_sclk_out,
    output logic                  spi_cs_out,
    output logic                  spi_mosi_out
);

    localparam int MAX_P = max4(HALF_DIV, CS_SETUP, CS_HOLD, CS_GAP);
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] LD_HALF  = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(CS_GAP - 1);

    if (HALF_DIV < SPI_MIN_HALF_DIV) begin : g_chk_half_div
        $error("spi_master_tx: HALF_DIV=%0d below minimum %0d", HALF_DIV, SPI_MIN_HALF_DIV);
    end
    if (CS_SETUP < SPI_MIN_CS_SETUP) begin : g_chk_cs_setup
        $error("spi_master_tx: CS_SETUP=%0d below minimum %0d", CS_SETUP, SPI_MIN_CS_SETUP);
    end
    if (CS_HOLD < SPI_MIN_CS_HOLD) begin : g_chk_cs_hold
        $error("spi_master_tx: CS_HOLD=%0d below minimum %0d", CS_HOLD, SPI_MIN_CS_HOLD);
    end
    if (CS_GAP < SPI_MIN_CS_GAP) begin : g_chk_cs_gap
        $error("spi_master_tx: CS_GAP=%0d below minimum %0d", CS_GAP, SPI_MIN_CS_GAP);
    end

    spi_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             last_q;
    logic             ready_q;
    logic             busy_q;
    logic             byte_done_q;
    logic             sclk_q;
    logic             cs_q;

    logic             xfer;
    logic             shift;
    logic             sh_mosi;
    logic             sh_last_bit;
    logic             sh_empty;

    assign xfer  = data_valid_in & ready_q;
    assign shift = (state == ST_HIGH) && (cnt == '0);

    spi_tx_shifter u_shifter (
        .clk      (clk_in),
        .rst      (reset_in),
        .load     (xfer),
        .data     (data_in),
        .shift    (shift),
        .mosi     (sh_mosi),
        .last_bit (sh_last_bit),
        .empty    (sh_empty)
    );

    // Frame sequencer: state, timing counter, handshake and SPI pin registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
        end else begin
            byte_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (xfer) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b0;
                        last_q  <= last_in;
                        cnt     <= LD_SETUP;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        sclk_q <= 1'b1;
                        cnt    <= LD_HALF;
                        state  <= ST_HIGH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt == '0) begin
                        sclk_q      <= 1'b0;
                        byte_done_q <= sh_last_bit;
                        cnt         <= LD_HALF;
                        state       <= ST_LOW;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt == '0) begin
                        if (sh_empty) begin
                            if (last_q) begin
                                cnt   <= LD_HOLD;
                                state <= ST_HOLD;
                            end else begin
                                ready_q <= 1'b1;
                                state   <= ST_NEXT;
                            end
                        end else begin
                            sclk_q <= 1'b1;
                            cnt    <= LD_HALF;
                            state  <= ST_HIGH;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    // Reuse SETUP with a HALF_DIV count as the lead-in before the first rise.
                    if (xfer) begin
                        ready_q <= 1'b0;
                        last_q  <= last_in;
                        cnt     <= LD_HALF;
                        state   <= ST_SETUP;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        cs_q  <= 1'b1;
                        cnt   <= LD_GAP;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_ready_out = ready_q;
    assign busy_out       = busy_q;
    assign byte_done_out  = byte_done_q;
    assign spi_sclk_out   = sclk_q;
    assign spi_cs_out     = cs_q;
    assign spi_mosi_out   = sh_mosi;

endmodule
